capture_ctrl: RTL
=================

CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-002 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port i_refresh, input, 1 bit: one-cycle frame pulse; all frame-based counters advance only on it.
REQ-004 SHALL have port i_throw, input, 1 bit: throw request pulse from player input.
REQ-005 SHALL have port i_catch_rate, input, 8 bits: capture threshold; 0 means never, 255 means always.
REQ-006 SHALL have port i_en_collision, input, 1 bit: collision detector reports collision sequence active.
REQ-007 SHALL have port i_anime_ball, input, 1 bit: collision detector reports ball-shake animation phase.
REQ-008 SHALL have port i_collision_done, input, 1 bit: collision detector reports shake sequence complete (level).
REQ-009 SHALL have port o_en_pokemon, output, 1 bit: pokemon sprite enable, also drives the detector's pokemon enable.
REQ-010 SHALL have port o_en_ball, output, 1 bit: ball sprite enable, also drives the detector's ball enable.
REQ-011 SHALL have port o_shake_frame, output, 2 bits: ball sprite frame index.
REQ-012 SHALL have port o_result_valid, output, 1 bit: one-cycle result strobe.
REQ-013 SHALL have port o_caught, output, 1 bit: result of the last throw (1 = captured).
REQ-014 SHALL have port o_catch_cnt, output, 8 bits: total captures since reset.
REQ-015 SHALL have port o_busy, output, 1 bit: high in every state except S_IDLE.

Function
REQ-016 SHALL implement states S_IDLE, S_FLIGHT, S_SHAKE, S_RESULT, S_HOLD.
REQ-017 S_IDLE: o_en_pokemon=1, o_en_ball=0; i_throw=1 SHALL move to S_FLIGHT next cycle, clear o_caught and the frame counter, and clear the miss flag.
REQ-018 i_throw SHALL be ignored in every state other than S_IDLE.
REQ-019 S_FLIGHT: o_en_pokemon=1, o_en_ball=1; a 7-bit frame counter SHALL increment on each i_refresh.
REQ-020 S_FLIGHT: i_en_collision=1 SHALL move to S_SHAKE and clear the frame counter.
REQ-021 S_FLIGHT: an i_refresh that makes the frame counter reach 90 without i_en_collision SHALL set the miss flag and move to S_RESULT.
REQ-022 If the timeout refresh and i_en_collision coincide in S_FLIGHT, collision SHALL win: go to S_SHAKE with the miss flag clear.
REQ-023 S_SHAKE: o_en_pokemon=0, o_en_ball=1.
REQ-024 S_SHAKE: while i_anime_ball=1, o_shake_frame SHALL increment on each i_refresh, wrapping 3->0.
REQ-025 S_SHAKE: while i_anime_ball=0, o_shake_frame SHALL be 0.
REQ-026 S_SHAKE: a rising edge of i_collision_done (registered previous-value compare) SHALL move to S_RESULT; a level already high on entry SHALL NOT trigger.
REQ-027 An 8-bit Fibonacci LFSR SHALL shift left every clock with new LSB = b7^b5^b4^b3, seeded 8'h5A at reset; it never reaches 0.
REQ-028 S_RESULT SHALL last exactly 1 cycle, with o_result_valid=1 only in that cycle.
REQ-029 On entry to S_RESULT, o_caught SHALL load (!miss && lfsr<=i_catch_rate), using the LFSR value of the entry cycle.
REQ-030 o_caught SHALL hold its value until the next accepted throw.
REQ-031 o_catch_cnt SHALL increment when o_result_valid=1 and o_caught=1, and saturate at 255.
REQ-032 S_RESULT SHALL go to S_HOLD with the frame counter cleared.
REQ-033 S_HOLD: o_en_pokemon=!o_caught, o_en_ball=o_caught, o_shake_frame=0.
REQ-034 S_HOLD: the 60th i_refresh SHALL return the block to S_IDLE.
REQ-035 All outputs SHALL be registered or decoded from state and registers only, with no combinational path from inputs.

Reset
REQ-036 On i_rst_n=0, state SHALL become S_IDLE immediately, regardless of current state.
REQ-037 On i_rst_n=0, all counters, the miss flag, o_caught, o_catch_cnt and o_shake_frame SHALL become 0.
REQ-038 During reset, o_en_pokemon=1, o_en_ball=0, o_result_valid=0, o_busy=0, and the LFSR SHALL be 8'h5A.
REQ-039 Reset asserted mid-S_SHAKE SHALL produce no o_result_valid pulse.

Verification
REQ-040 Miss: i_throw, no i_en_collision, 90 refreshes -> o_result_valid pulse with o_caught=0, o_catch_cnt unchanged, o_en_pokemon=1 in S_HOLD.
REQ-041 Capture: i_catch_rate=255, throw, i_en_collision, i_anime_ball for 6 refreshes, i_collision_done rise -> o_shake_frame sequence 1,2,3,0,1,2, then o_caught=1, o_catch_cnt=1, o_en_ball=1, o_en_pokemon=0.
REQ-042 Never catch: i_catch_rate=0 with full shake sequence -> o_caught=0.
REQ-043 Timeout tie: i_en_collision asserted on the same cycle as the 90th refresh -> state goes to S_SHAKE, no result pulse.
REQ-044 Throw rejection and saturation: i_throw during S_SHAKE/S_HOLD is ignored; after 256 forced captures, o_catch_cnt=255.
REQ-045 Async reset: reset pulse mid-S_SHAKE -> immediate S_IDLE, o_shake_frame=0, o_result_valid stays 0.

Source files
------------

// File: rtl/capture_ctrl.sv
// Capture sequencer: ball flight, shake animation, random capture decision and
// post-result hold, with a running saturating capture count.
module capture_ctrl (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_refresh,
   input  logic       i_throw,
   input  logic [7:0] i_catch_rate,
   input  logic       i_en_collision,
   input  logic       i_anime_ball,
   input  logic       i_collision_done,
   output logic       o_en_pokemon,
   output logic       o_en_ball,
   output logic [1:0] o_shake_frame,
   output logic       o_result_valid,
   output logic       o_caught,
   output logic [7:0] o_catch_cnt,
   output logic       o_busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FLIGHT,
      S_SHAKE,
      S_RESULT,
      S_HOLD
   } state_t;

   localparam logic [6:0] FLIGHT_LAST = 7'd89;
   localparam logic [6:0] HOLD_LAST   = 7'd59;
   localparam logic [7:0] LFSR_SEED   = 8'h5A;

   state_t     state;
   state_t     state_nxt;
   logic [6:0] frame_cnt;
   logic       miss;
   logic       done_q;
   logic [7:0] lfsr;
   logic [1:0] shake;
   logic       caught;
   logic [7:0] catch_cnt;

   logic       frame_clr;
   logic       frame_inc;
   logic       miss_clr;
   logic       miss_set;
   logic       caught_clr;
   logic       caught_load;
   logic       shake_clr;
   logic       done_rise;
   logic       caught_hit;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   assign done_rise  = i_collision_done & ~done_q;
   // A timeout entry must report a miss even though the flag is only being set now.
   assign caught_hit = ~miss & ~miss_set & (lfsr <= i_catch_rate);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      frame_clr   = 1'b0;
      frame_inc   = 1'b0;
      miss_clr    = 1'b0;
      miss_set    = 1'b0;
      caught_clr  = 1'b0;
      caught_load = 1'b0;
      shake_clr   = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_throw) begin
               state_nxt  = S_FLIGHT;
               frame_clr  = 1'b1;
               miss_clr   = 1'b1;
               caught_clr = 1'b1;
            end
         end
         S_FLIGHT: begin
            frame_inc = i_refresh;
            if (i_en_collision) begin
               state_nxt = S_SHAKE;
               frame_clr = 1'b1;
               shake_clr = 1'b1;
            end else if (i_refresh && (frame_cnt == FLIGHT_LAST)) begin
               state_nxt   = S_RESULT;
               miss_set    = 1'b1;
               caught_load = 1'b1;
            end
         end
         S_SHAKE: begin
            if (done_rise) begin
               state_nxt   = S_RESULT;
               caught_load = 1'b1;
            end
         end
         S_RESULT: begin
            state_nxt = S_HOLD;
            frame_clr = 1'b1;
         end
         S_HOLD: begin
            frame_inc = i_refresh;
            if (i_refresh && (frame_cnt == HOLD_LAST)) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         frame_cnt <= '0;
         miss      <= 1'b0;
         done_q    <= 1'b0;
         lfsr      <= LFSR_SEED;
      end else begin
         done_q <= i_collision_done;
         lfsr   <= lfsr_step(lfsr);
         if (frame_clr) begin
            frame_cnt <= '0;
         end else if (frame_inc) begin
            frame_cnt <= frame_cnt + 7'd1;
         end
         if (miss_clr) begin
            miss <= 1'b0;
         end else if (miss_set) begin
            miss <= 1'b1;
         end
      end
   end

   // Shake frame only advances on frames of the ball-shake animation phase.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         shake <= '0;
      end else if (shake_clr) begin
         shake <= '0;
      end else if (state == S_SHAKE) begin
         if (!i_anime_ball) begin
            shake <= '0;
         end else if (i_refresh) begin
            shake <= shake + 2'd1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         caught    <= 1'b0;
         catch_cnt <= '0;
      end else begin
         if (caught_clr) begin
            caught <= 1'b0;
         end else if (caught_load) begin
            caught <= caught_hit;
         end
         if ((state == S_RESULT) && caught) begin
            catch_cnt <= sat_inc(catch_cnt);
         end
      end
   end

   always_comb begin
      o_en_pokemon = 1'b1;
      o_en_ball    = 1'b0;
      case (state)
         S_FLIGHT: begin
            o_en_pokemon = 1'b1;
            o_en_ball    = 1'b1;
         end
         S_SHAKE: begin
            o_en_pokemon = 1'b0;
            o_en_ball    = 1'b1;
         end
         S_RESULT, S_HOLD: begin
            o_en_pokemon = ~caught;
            o_en_ball    = caught;
         end
         default: begin
            o_en_pokemon = 1'b1;
            o_en_ball    = 1'b0;
         end
      endcase
   end

   assign o_shake_frame  = (state == S_SHAKE) ? shake : 2'd0;
   assign o_result_valid = (state == S_RESULT);
   assign o_busy         = (state != S_IDLE);
   assign o_caught       = caught;
   assign o_catch_cnt    = catch_cnt;

endmodule
